// File: rtl/servo_cmd_ramp_pkg.sv
// rtl/servo_cmd_ramp_pkg.sv - shared constants and FSM encoding for the servo command path
//
// Default timing constants and the 2-bit state encoding shared by the servo
// command stage and the PWM generator.
package servo_cmd_ramp_pkg;

  localparam int unsigned DEF_W            = 32;
  localparam int unsigned DEF_FRAME_CYCLES = 1000000;  // 20 ms at 50 MHz
  localparam int unsigned DEF_MIN_WIDTH    = 50000;    // 1 ms
  localparam int unsigned DEF_MAX_WIDTH    = 100000;   // 2 ms
  localparam int unsigned DEF_CENTER_WIDTH = 75000;    // 1.5 ms
  localparam int unsigned DEF_STEP         = 500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_JUMP = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - free-running PWM frame counter with frame-start strobe
//
// Ports:
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   frame_last_o   high while the counter sits on the last cycle of a frame
//                  (the edge that ends this cycle is the frame boundary)
//   frame_start_o  registered strobe, high on the first cycle of each frame
module servo_frame_timer
  import servo_cmd_ramp_pkg::*;
#(
  parameter int unsigned W            = DEF_W,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic frame_last_o,
  output logic frame_start_o
);

  localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         start_q;

  assign frame_last_o  = (cnt_q == LAST_CNT);
  assign frame_start_o = start_q;

  always_comb begin
    cnt_d = frame_last_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= frame_last_o;
    end
  end

endmodule

// File: rtl/servo_cmd_ramp.sv
// rtl/servo_cmd_ramp.sv - clamps servo width commands and slews the active width once per frame
//
// Ports:
//   clock_clk      system clock
//   reset_low      synchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      command accepted when cmd_valid & cmd_ready at a posedge
//   cmd_width      requested pulse width in clocks
//   cmd_immediate  1 = jump to target at next frame, 0 = ramp by STEP per frame
//   width_out      active pulse width, changes only on the edge raising frame_start
//   frame_start    one-cycle strobe on the first cycle of each frame
//   busy           high while width_out differs from target
//   clamp_flag     one-cycle pulse after accepting an out-of-range width
module servo_cmd_ramp
  import servo_cmd_ramp_pkg::*;
#(
  parameter int unsigned W            = DEF_W,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned MIN_WIDTH    = DEF_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH    = DEF_MAX_WIDTH,
  parameter int unsigned CENTER_WIDTH = DEF_CENTER_WIDTH,
  parameter int unsigned STEP         = DEF_STEP
) (
  input  logic         clock_clk,
  input  logic         reset_low,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_width,
  input  logic         cmd_immediate,
  output logic [W-1:0] width_out,
  output logic         frame_start,
  output logic         busy,
  output logic         clamp_flag
);

  localparam logic [W-1:0] MIN_W    = W'(MIN_WIDTH);
  localparam logic [W-1:0] MAX_W    = W'(MAX_WIDTH);
  localparam logic [W-1:0] CENTER_W = W'(CENTER_WIDTH);
  localparam logic [W-1:0] STEP_W   = W'(STEP);

  ramp_state_e  state_q, state_d;
  logic [W-1:0] width_q, width_d;
  logic [W-1:0] target_q, target_d;
  logic         imm_q, imm_d;
  logic         clamp_q, clamp_d;
  logic         busy_q;
  logic         ready_q;
  logic         frame_last;
  logic         accept;
  logic [W-1:0] cmd_clamped;
  logic         cmd_out_of_range;

  servo_frame_timer #(
    .W            (W),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_frame_timer (
    .clk_i         (clock_clk),
    .rst_ni        (reset_low),
    .frame_last_o  (frame_last),
    .frame_start_o (frame_start)
  );

  assign accept           = cmd_valid & ready_q;
  assign cmd_out_of_range = (cmd_width < MIN_W) | (cmd_width > MAX_W);
  assign cmd_clamped      = (cmd_width < MIN_W) ? MIN_W :
                            (cmd_width > MAX_W) ? MAX_W : cmd_width;

  assign cmd_ready  = ready_q;
  assign width_out  = width_q;
  assign busy       = busy_q;
  assign clamp_flag = clamp_q;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    target_d = target_q;
    imm_d    = imm_q;
    clamp_d  = 1'b0;

    // The boundary is resolved with the target/mode held before this edge;
    // a command accepted on the same edge only takes effect next frame.
    if (frame_last) begin
      case (state_q)
        ST_RAMP: begin
          if (target_q > width_q) begin
            width_d = ((target_q - width_q) > STEP_W) ? width_q + STEP_W : target_q;
          end else begin
            width_d = ((width_q - target_q) > STEP_W) ? width_q - STEP_W : target_q;
          end
          if (width_d == target_q) begin
            state_d = ST_IDLE;
          end
        end
        ST_JUMP: begin
          width_d = target_q;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end

    // A new command re-decides the state against the width that will be
    // active after this edge.
    if (accept) begin
      target_d = cmd_clamped;
      imm_d    = cmd_immediate;
      clamp_d  = cmd_out_of_range;
      if (cmd_clamped == width_d) begin
        state_d = ST_IDLE;
      end else begin
        state_d = cmd_immediate ? ST_JUMP : ST_RAMP;
      end
    end
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_low) begin
      state_q  <= ST_IDLE;
      width_q  <= CENTER_W;
      target_q <= CENTER_W;
      imm_q    <= 1'b0;
      clamp_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      target_q <= target_d;
      imm_q    <= imm_d;
      clamp_q  <= clamp_d;
      busy_q   <= (state_d != ST_IDLE);
      ready_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// tb/tb_servo_cmd_ramp.sv - self-checking bench for servo_cmd_ramp
module tb_servo_cmd_ramp;

  localparam int W    = 32;
  localparam int FC   = 100;
  localparam int MINW = 10;
  localparam int MAXW = 30;
  localparam int CW   = 20;
  localparam int STP  = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_imm = 1'b0;
  logic [W-1:0] cmd_width = '0;
  logic         cmd_ready;
  logic [W-1:0] width_out;
  logic         frame_start;
  logic         busy;
  logic         clamp_flag;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;
  int k;

  always #5 clk = ~clk;

  servo_cmd_ramp #(
    .W            (W),
    .FRAME_CYCLES (FC),
    .MIN_WIDTH    (MINW),
    .MAX_WIDTH    (MAXW),
    .CENTER_WIDTH (CW),
    .STEP         (STP)
  ) dut (
    .clock_clk     (clk),
    .reset_low     (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_width     (cmd_width),
    .cmd_immediate (cmd_imm),
    .width_out     (width_out),
    .frame_start   (frame_start),
    .busy          (busy),
    .clamp_flag    (clamp_flag)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: cycles since reset define the frames; the width
  // walks toward the target on each frame boundary using the mode of the
  // command in force before that edge.
  longint m_n = 0;
  longint m_width = CW;
  longint m_target = CW;
  bit     m_imm = 1'b0;
  bit     m_ready = 1'b0;
  bit     m_clamp = 1'b0;
  bit     m_start = 1'b0;

  always @(posedge clk) begin
    longint raw;
    longint diff;
    bit     acc;
    if (!rstn) begin
      m_n = 0; m_width = CW; m_target = CW; m_imm = 1'b0;
      m_ready = 1'b0; m_clamp = 1'b0; m_start = 1'b0;
    end else begin
      acc = cmd_valid && m_ready;
      raw = longint'(cmd_width);
      m_n++;
      m_start = (m_n % FC == 0);
      if (m_start && m_width != m_target) begin
        if (m_imm) m_width = m_target;
        else begin
          diff = (m_target > m_width) ? m_target - m_width : m_width - m_target;
          if (diff > STP) diff = STP;
          m_width = (m_target > m_width) ? m_width + diff : m_width - diff;
        end
      end
      m_clamp = 1'b0;
      if (acc) begin
        m_target = (raw < MINW) ? MINW : (raw > MAXW) ? MAXW : raw;
        m_imm    = cmd_imm;
        m_clamp  = (raw < MINW) || (raw > MAXW);
      end
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_width", width_out, m_width);
      check("model_frame_start", frame_start, m_start);
      check("model_busy", busy, m_width != m_target);
      check("model_clamp", clamp_flag, m_clamp);
      check("model_ready", cmd_ready, m_ready);
    end
  end

  task automatic send(input int w, input bit imm);
    cmd_width = W'(w);
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame_start && cycles < 300);
    if (!frame_start) check("strobe_timeout", frame_start, 1);
  endtask

  initial begin
    rstn = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_width", width_out, 20);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_frame_start", frame_start, 0);
    rstn = 1'b1;

    wait_strobe(k);
    check("first_strobe_cycle", k, 100);
    check("idle_width", width_out, 20);
    check("idle_busy", busy, 0);
    wait_strobe(k);
    check("strobe_period", k, 100);

    repeat (10) @(negedge clk);
    send(30, 1'b0);
    check("ramp_busy", busy, 1);
    check("ramp_hold", width_out, 20);
    wait_strobe(k);
    check("ramp_w1", width_out, 24);
    wait_strobe(k);
    check("ramp_w2", width_out, 28);
    check("ramp_busy2", busy, 1);
    wait_strobe(k);
    check("ramp_w3", width_out, 30);
    check("ramp_done_busy", busy, 0);

    repeat (5) @(negedge clk);
    send(50, 1'b0);
    check("clamp_hi", clamp_flag, 1);
    check("clamp_hi_busy", busy, 0);
    @(negedge clk);
    check("clamp_pulse_end", clamp_flag, 0);
    send(3, 1'b0);
    check("clamp_lo", clamp_flag, 1);
    check("clamp_lo_busy", busy, 1);
    send(10, 1'b0);
    check("min_no_clamp", clamp_flag, 0);
    send(20, 1'b1);
    wait_strobe(k);
    check("jump_back_20", width_out, 20);

    repeat (3) @(negedge clk);
    send(12, 1'b1);
    wait_strobe(k);
    check("jump_12", width_out, 12);
    check("jump_idle", busy, 0);

    send(20, 1'b1);
    wait_strobe(k);
    check("jump_to_20", width_out, 20);
    repeat (99) @(negedge clk);
    send(30, 1'b0);
    check("bnd_strobe", frame_start, 1);
    check("bnd_width_kept", width_out, 20);
    check("bnd_busy", busy, 1);
    wait_strobe(k);
    check("bnd_next_frame", width_out, 24);

    repeat (7) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_width", width_out, 20);
    check("midreset_busy", busy, 0);
    check("midreset_strobe", frame_start, 0);
    rstn = 1'b1;
    wait_strobe(k);
    check("post_reset_strobe", k, 100);
    check("post_reset_width", width_out, 20);
    check("post_reset_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
